plab2_proc_muldiv_iterative: RTL
================================

// Module: plab2_proc_muldiv_iterative
// PURPOSE
//  Iterative 32-bit integer multiply/divide unit for the pipelined processor X stage.
//  Consumes operands read from the register file, in parallel with the single-cycle ALU.
//  Result feeds the X/M pipeline register. Handshake is val/rdy on both sides.
//  One operation in flight; the control unit stalls X while the unit is busy.
// PARAMETERS
//  p_nbits   32   operand/result width; counter width is clog2(p_nbits)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-low reset
//  req_val    in   1    request valid
//  req_rdy    out  1    unit can accept a request
//  req_fn     in   3    0 mul, 1 div, 2 divu, 3 rem, 4 remu; 5-7 reserved
//  req_a      in   32   operand a (multiplicand / dividend), from rs
//  req_b      in   32   operand b (multiplier / divisor), from rt
//  resp_val   out  1    result valid
//  resp_rdy   in   1    downstream accepts result
//  resp_data  out  32   result
// BEHAVIOUR
//  - Reset (reset=0, any time): state=IDLE, req_rdy=1, resp_val=0, resp_data=0, counter=0.
//    Reset mid-operation aborts the operation; no response is produced.
//  - FSM IDLE -> CALC on req_val&&req_rdy: latch fn; latch |a|,|b| for signed fns, raw for unsigned;
//    latch sign_q=a[31]^b[31], sign_r=a[31].
//  - CALC: exactly p_nbits cycles, one shift-add (mul) or restoring shift-subtract (div/rem)
//    step per cycle; counter counts 0..p_nbits-1; CALC -> DONE after the last step.
//  - DONE: resp_val=1; resp_data holds the sign-corrected result; DONE -> IDLE on resp_rdy.
//    resp_data and resp_val are stable while resp_rdy=0.
//  - req_rdy=1 only in IDLE (no same-cycle DONE->accept bypass). Latency: resp_val rises
//    exactly p_nbits+1 cycles after the accepting edge (33 for 32-bit).
//  - mul: low 32 bits of a*b; signed and unsigned give identical low bits.
//  - Divide by zero: div/divu -> 32'hffffffff; rem/remu -> a unchanged. Still full latency.
//  - Signed overflow: div 32'h80000000 / 32'hffffffff -> 32'h80000000; rem -> 0.
//  - Quotient is negated if sign_q (and b!=0); remainder takes the sign of a (truncation).
//  - Reserved fn: completes with normal latency, resp_data=0.
//  - req_* are ignored unless req_val&&req_rdy; inputs change freely while busy.
// CONFIGURATION
//  PLAB2_PROC_MULDIV_DIV_EN defined: all five fns supported as above.
//  Undefined: divider datapath and remainder register are omitted; fn 1-4 are treated as
//  reserved (resp_data=0, normal latency); mul is unchanged.
// STRUCTURE
//  - Shared package/header plab2-proc-muldiv-msgs: fn codes
//    (MULDIV_FN_MUL..MULDIV_FN_REMU), state encodings (IDLE, CALC, DONE), p_nbits default.
//  - One sub-module: plab2_proc_muldiv_ctrl (FSM + step counter, emits load/step/done
//    controls). Datapath registers, shifter, adder/subtractor and sign fix-up are in the top.
// TESTING
//  - Reset held low mid-CALC (cycle 10 after accept) -> req_rdy=1, resp_val=0 next cycle;
//    the next request completes correctly.
//  - mul: 3 * 32'hfffffffc -> 32'hfffffff4; 32'h0000ffff * 32'h0000ffff -> 32'hfffe0001;
//    resp_val exactly 33 cycles after accept.
//  - div/rem: -7,2 -> div 32'hfffffffd, rem 32'hffffffff; divu 32'hfffffff9,2 -> 32'h7ffffffc,
//    remu -> 1.
//  - Edge cases: div 5/0 -> 32'hffffffff; rem 5/0 -> 5;
//    div 32'h80000000/32'hffffffff -> 32'h80000000, rem -> 0.
//  - Backpressure: resp_rdy=0 for 5 cycles in DONE -> resp_val/resp_data held, req_rdy=0;
//    IDLE one cycle after resp_rdy=1.
//  - Config: without PLAB2_PROC_MULDIV_DIV_EN, div 10/2 -> 0 and mul 6*7 -> 42;
//    fn 7 -> 0 in both builds.

Source files
------------

// File: rtl/plab2_proc_muldiv_iterative_pkg.sv
// plab2_proc_muldiv_iterative_pkg: function codes, FSM states and default width for the muldiv unit
package plab2_proc_muldiv_iterative_pkg;

    localparam int P_NBITS = 32;

    typedef enum logic [2:0] {
        MULDIV_FN_MUL  = 3'd0,
        MULDIV_FN_DIV  = 3'd1,
        MULDIV_FN_DIVU = 3'd2,
        MULDIV_FN_REM  = 3'd3,
        MULDIV_FN_REMU = 3'd4
    } muldiv_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/plab2_proc_muldiv_iterative_if.sv
// plab2_proc_muldiv_iterative_if: val/rdy request and response bundle for the muldiv unit
interface plab2_proc_muldiv_iterative_if
    import plab2_proc_muldiv_iterative_pkg::*;
#(
    parameter int p_nbits = P_NBITS
);

    logic               req_val;
    logic               req_rdy;
    logic [2:0]         req_fn;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;
    logic               resp_val;
    logic               resp_rdy;
    logic [p_nbits-1:0] resp_data;

    modport master (
        output req_val, req_fn, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_fn, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_data
    );

endinterface

// File: rtl/plab2_proc_muldiv_ctrl.sv
// plab2_proc_muldiv_ctrl: IDLE/CALC/DONE sequencer and step counter; CALC ends with one result fix-up cycle
module plab2_proc_muldiv_ctrl
    import plab2_proc_muldiv_iterative_pkg::*;
#(
    parameter int p_nbits = P_NBITS
) (
    input  logic clk,
    input  logic reset,
    input  logic req_val,
    input  logic resp_rdy,
    output logic req_rdy,
    output logic resp_val,
    output logic load,
    output logic step,
    output logic fix
);

    localparam int CW = $clog2(p_nbits);

    state_e        state, next_state;
    logic [CW-1:0] cnt;
    logic          fix_q;

    assign req_rdy  = state == IDLE;
    assign resp_val = state == DONE;
    assign load     = req_rdy && req_val;
    assign step     = state == CALC && !fix_q;
    assign fix      = state == CALC && fix_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req_val  ? CALC : IDLE;
            CALC:    next_state = fix_q    ? DONE : CALC;
            DONE:    next_state = resp_rdy ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    // Step counter 0..p_nbits-1; flags the fix-up cycle after the final step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            fix_q <= 1'b0;
        end else if (step) begin
            cnt   <= cnt + 1'b1;
            fix_q <= cnt == CW'(p_nbits - 1);
        end else if (fix) begin
            fix_q <= 1'b0;
        end
    end

endmodule

// File: rtl/plab2_proc_muldiv_iterative.sv
// plab2_proc_muldiv_iterative: iterative shift-add multiply / restoring divide; PLAB2_PROC_MULDIV_DIV_EN enables div/rem
module plab2_proc_muldiv_iterative
    import plab2_proc_muldiv_iterative_pkg::*;
#(
    parameter int p_nbits = P_NBITS
) (
    input logic                          clk,
    input logic                          reset,
    plab2_proc_muldiv_iterative_if.slave bus
);

    logic               load, step, fix;
    muldiv_fn_e         fn_q;
    logic [p_nbits-1:0] a_reg, b_reg, acc, result, resp_data_q;

    plab2_proc_muldiv_ctrl #(.p_nbits(p_nbits)) ctrl (
        .clk      (clk),
        .reset    (reset),
        .req_val  (bus.req_val),
        .resp_rdy (bus.resp_rdy),
        .req_rdy  (bus.req_rdy),
        .resp_val (bus.resp_val),
        .load     (load),
        .step     (step),
        .fix      (fix)
    );

    assign bus.resp_data = resp_data_q;

`ifdef PLAB2_PROC_MULDIV_DIV_EN
    logic             req_signed, neg_q, neg_r;
    logic [p_nbits:0] rem_sh, diff;
    assign req_signed = bus.req_fn == MULDIV_FN_DIV || bus.req_fn == MULDIV_FN_REM;
    assign rem_sh     = {acc, a_reg[p_nbits-1]};
    assign diff       = rem_sh - {1'b0, b_reg};
`endif

    // Latch operands on accept, then one shift-add (mul) or shift-subtract (div) step per cycle.
    // For division a_reg shifts dividend bits out and quotient bits in; acc is the partial remainder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_q  <= MULDIV_FN_MUL;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
`ifdef PLAB2_PROC_MULDIV_DIV_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (load) begin
            fn_q  <= muldiv_fn_e'(bus.req_fn);
            acc   <= '0;
`ifdef PLAB2_PROC_MULDIV_DIV_EN
            a_reg <= (req_signed && bus.req_a[p_nbits-1]) ? -bus.req_a : bus.req_a;
            b_reg <= (req_signed && bus.req_b[p_nbits-1]) ? -bus.req_b : bus.req_b;
            neg_q <= bus.req_fn == MULDIV_FN_DIV && (bus.req_a[p_nbits-1] ^ bus.req_b[p_nbits-1])
                     && bus.req_b != '0;
            neg_r <= bus.req_fn == MULDIV_FN_REM && bus.req_a[p_nbits-1];
`else
            a_reg <= bus.req_a;
            b_reg <= bus.req_b;
`endif
        end else if (step) begin
            if (fn_q == MULDIV_FN_MUL) begin
                acc   <= acc + (b_reg[0] ? a_reg : '0);
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
            end
`ifdef PLAB2_PROC_MULDIV_DIV_EN
            else begin
                acc   <= diff[p_nbits] ? rem_sh[p_nbits-1:0] : diff[p_nbits-1:0];
                a_reg <= {a_reg[p_nbits-2:0], ~diff[p_nbits]};
            end
`endif
        end
    end

    // Sign fix-up and function select; reserved codes yield zero
    always_comb begin
`ifdef PLAB2_PROC_MULDIV_DIV_EN
        result = fn_q == MULDIV_FN_MUL ? acc :
                 (fn_q == MULDIV_FN_DIV || fn_q == MULDIV_FN_DIVU) ? (neg_q ? -a_reg : a_reg) :
                 (fn_q == MULDIV_FN_REM || fn_q == MULDIV_FN_REMU) ? (neg_r ? -acc : acc) : '0;
`else
        result = fn_q == MULDIV_FN_MUL ? acc : '0;
`endif
    end

    // Response register, loaded in the fix-up cycle and held through DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   resp_data_q <= '0;
        else if (fix) resp_data_q <= result;
    end

endmodule
